// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed 7-segment driver.
//   seg_t         7-bit segment vector {a,b,c,d,e,f,g}, active low
//   SEG_BLANK     all segments off
//   SEG_ALL_ON    all segments lit (lamp test)
//   GLYPH_TABLE   hex glyphs 0..F; code F renders blank
//   seg7_decode   nibble -> glyph lookup
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK  = 7'b1111111;
  localparam seg_t SEG_ALL_ON = 7'b0000000;

  localparam seg_t GLYPH_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b1100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b1110010, 7'b1100110,
    7'b1011100, 7'b0110100, 7'b1110000, 7'b1111111
  };

  function automatic seg_t seg7_decode(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational hex nibble to active-low segment pattern.
//   i_nibble  4-bit hex code
//   o_seg     {a,b,c,d,e,f,g}, active low
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = seg7_decode(i_nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit common-anode display driver.
//   clk, rst   system clock (rising edge), asynchronous active-high reset
//   data_in    hex nibbles, digit 0 in bits [3:0]; captured when load=1
//   load       capture strobe for data_in (and dp_in)
//   lt_n       lamp test, active low
//   bi_n       blanking input, active low; highest priority
//   rbi_n      ripple-blank input, active low; enables leading-zero suppression
//   seg        shared segment bus {a..g}, active low, registered
//   an         digit enables, active low, one-hot-low, registered
//   rbo_n      0 when every digit above digit 0 is suppressed, registered
// Optional macro SEG7_DP_EN adds dp_in (per-digit decimal point, captured
// with load) and dp_n (active-low decimal point, registered with seg).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic                  load,
  input  logic                  lt_n,
  input  logic                  bi_n,
  input  logic                  rbi_n,
`ifdef SEG7_DP_EN
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  dp_n,
`endif
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  rbo_n
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic [4*N_DIGITS-1:0] r_data;
  logic [CNT_W-1:0]      r_scan_cnt;
  logic [IDX_W-1:0]      r_dig_idx;
  logic [6:0]            r_seg;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_rbo_n;

  logic                  w_wrap;
  logic                  w_zero_hi;
  logic                  w_all_sup;
  logic [N_DIGITS-1:0]   w_sup;
  logic [3:0]            w_nib;
  logic                  w_sup_cur;
  logic [6:0]            w_glyph;
  logic [6:0]            w_seg_nxt;
  logic [N_DIGITS-1:0]   w_an_nxt;
  logic                  w_rbo_nxt;

  assign w_wrap = (r_scan_cnt == CNT_W'(SCAN_DIV - 1));

  // Walk from the most significant digit down: a digit is suppressed while
  // it and every nibble above it are zero. Digit 0 is never suppressed.
  always_comb begin
    w_sup     = '0;
    w_zero_hi = 1'b1;
    w_all_sup = 1'b1;
    for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
      w_zero_hi = w_zero_hi & (r_data[4*i +: 4] == 4'h0);
      w_sup[i]  = ~rbi_n & w_zero_hi;
      w_all_sup = w_all_sup & w_sup[i];
    end
  end

  // A single-digit display has no upper digits to suppress.
  assign w_rbo_nxt = (N_DIGITS > 1) ? ~w_all_sup : 1'b1;

  always_comb begin
    w_nib     = 4'h0;
    w_sup_cur = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (r_dig_idx == IDX_W'(i)) begin
        w_nib     = r_data[4*i +: 4];
        w_sup_cur = w_sup[i];
      end
    end
  end

  seg7_glyph u_glyph (
    .i_nibble (w_nib),
    .o_seg    (w_glyph)
  );

  always_comb begin
    w_seg_nxt = w_sup_cur ? SEG_BLANK : w_glyph;
    w_an_nxt  = ~(N_DIGITS'(1) << r_dig_idx);
    if (!bi_n) begin
      w_seg_nxt = SEG_BLANK;
      w_an_nxt  = '1;
    end else if (!lt_n) begin
      w_seg_nxt = SEG_ALL_ON;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_scan_cnt <= '0;
      r_dig_idx  <= '0;
      r_seg      <= SEG_BLANK;
      r_an       <= '1;
      r_rbo_n    <= 1'b1;
    end else begin
      if (load) begin
        r_data <= data_in;
      end
      if (w_wrap) begin
        r_scan_cnt <= '0;
        r_dig_idx  <= (r_dig_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_dig_idx + IDX_W'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      r_rbo_n <= w_rbo_nxt;
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign rbo_n = r_rbo_n;

`ifdef SEG7_DP_EN
  logic [N_DIGITS-1:0] r_dp;
  logic                r_dp_n;
  logic                w_dp_bit;
  logic                w_dp_n_nxt;

  always_comb begin
    w_dp_bit = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (r_dig_idx == IDX_W'(i)) begin
        w_dp_bit = r_dp[i];
      end
    end
  end

  // Decimal point follows blank/lamp-test priority but ignores suppression.
  always_comb begin
    w_dp_n_nxt = ~w_dp_bit;
    if (!bi_n) begin
      w_dp_n_nxt = 1'b1;
    end else if (!lt_n) begin
      w_dp_n_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp   <= '0;
      r_dp_n <= 1'b1;
    end else begin
      if (load) begin
        r_dp <= dp_in;
      end
      r_dp_n <= w_dp_n_nxt;
    end
  end

  assign dp_n = r_dp_n;
`endif

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised successor to the single-digit BCD/hex-to-7-segment decoder.
- Drives an N-digit common-anode display by time-multiplexing one shared segment bus over N active-low digit enables.
- Keeps lamp-test, blanking-input and ripple-blanking (leading-zero suppression) semantics, with a registered data snapshot and scan timing.
- Sits between register/counter logic and the board display pins.

Parameters:
- N_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- SCAN_DIV, 1000, clock cycles each digit stays enabled; legal range >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  4*N_DIGITS  hex nibbles; digit 0 = bits [3:0] = least significant.
- load  in  1  when 1 at a clock edge, data_in is captured into the internal data register.
- lt_n  in  1  lamp test, active low.
- bi_n  in  1  blanking input, active low; turns the whole display off.
- rbi_n  in  1  ripple-blank input, active low; enables leading-zero suppression.
- seg  out  7  {a,b,c,d,e,f,g}, active low (0 = segment lit).
- an  out  N_DIGITS  digit enables, active low, one-hot-low.
- rbo_n  out  1  0 when every digit above digit 0 is currently suppressed (for cascading).

Behaviour:
- Reset (async, rst=1):
  - data_reg = 0; scan_cnt = 0; dig_idx = 0.
  - seg = 7'b1111111; an = all 1s; rbo_n = 1.
- Scan timing:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On each wrap, dig_idx increments modulo N_DIGITS (N-1 -> 0).
  - N_DIGITS=1: dig_idx stays 0.
- Outputs:
  - seg and an are registered and reflect the dig_idx and data_reg values present before the edge: one cycle latency.
  - The first edge after reset release drives an = ~(1<<0).
- Glyph table (seg, active low), 0..F:
  - 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 1100000, 0001111
  - 0000000, 0001100, 1110010, 1100110, 1011100, 0110100, 1110000, 1111111
  - Code F renders blank.
- Suppression mask:
  - Digit k (k >= 1) is suppressed when rbi_n=0 and data_reg nibbles k..N-1 are all zero.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
  - A suppressed digit drives seg = 1111111; an still pulses normally.
  - Mask is derived combinationally from data_reg; there is no extra latency.
- rbo_n = registered ~(all digits 1..N-1 suppressed). Value is 1 when N_DIGITS=1.
- Priority (highest first):
  - bi_n=0: seg = 1111111, an = all 1s; scan counters keep running.
  - lt_n=0: seg = 0000000, an scans normally.
  - Otherwise: glyph or suppression as above.
- load:
  - Capture occurs at the edge where load=1.
  - The new data appears on seg at the next edge.
  - The scan position is not disturbed.
  - Simultaneous load and digit advance: the new digit shows the new data one cycle later.
- Reset mid-scan: everything returns immediately (asynchronously) to the reset values; scanning restarts at digit 0.

Optional Feature:
- Macro: SEG7_DP_EN.
- When defined:
  - Adds dp_in (in, N_DIGITS), captured with load.
  - Adds dp_n (out, 1, active low), registered alongside seg.
  - dp_n = ~dp_reg[dig_idx].
  - dp_n is forced to 1 under bi_n=0, forced to 0 under lt_n=0, and not affected by suppression.
- When undefined: no dp ports and no dp logic.

Decomposition:
- Package seg7_pkg:
  - 16-entry glyph constant array.
  - SEG_BLANK = 7'b1111111 and SEG_ALL_ON = 7'b0000000.
  - Function seg7_decode(nibble) -> 7 bits.
- Sub-module seg7_glyph: combinational nibble -> seg lookup using the package table.
- seg7_scan_driver holds the scan counter, digit index, data/suppression logic and output registers.

Test Plan (N_DIGITS=4, SCAN_DIV=4):
- Reset held, then released:
  - During reset: seg=1111111, an=1111.
  - 1 edge after release: an=1110.
  - 4 edges later: an=1101; full rotation to 0111, then back to 1110.
- load data_in=16'h12AF, rbi_n=1: while an=1110, seg=1111111 (F); an=1101 -> 1110010; an=1011 -> 0010010; an=0111 -> 1001111.
- load 16'h0005, rbi_n=0:
  - Digits 3..1 give seg=1111111 while their an bit is low; digit 0 gives seg=0100100.
  - rbo_n=0.
  - Repeat with rbi_n=1: digits 3..1 show 0000001 and rbo_n=1.
- load 16'h0000, rbi_n=0: only digit 0 shows 0000001; rbo_n=0.
- lt_n=0 with bi_n=1: seg=0000000 on every digit. bi_n=0 with lt_n=0: seg=1111111 and an=1111. Releasing bi_n resumes at the current scan position.
- Assert rst mid-rotation (an=1011): seg and an go to reset values within the same cycle; after release, scanning restarts at an=1110 and data_reg reads 0.
